// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: shared defaults and types for the reg_ctrl_unit register bank.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH / DEF_DEPTH / DEF_RESET_VAL : default geometry
//   state_t : read handshake state (IDLE = ready, BUSY = read in flight)
package reg_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_DEPTH      = 256;
  localparam logic [15:0] DEF_RESET_VAL  = 16'h1234;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rif.sv
// rif: bus-facing interface of the register bank.
//   clk   : bus clock (port)
//   rst   : asynchronous active-high reset
//   addr/sel/wr/wdata : request from the master
//   rdata/ready       : response from the register bank
// Modports: dut (register bank side), tb (master side).
interface rif
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic clk
);

  logic                  rst;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  sel;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport dut (
    input  clk, rst, addr, sel, wr, wdata,
    output rdata, ready
  );

  modport tb (
    input  clk, rdata, ready,
    output rst, addr, sel, wr, wdata
  );

endinterface

// File: rtl/reg_ctrl_unit.sv
// reg_ctrl_unit: bank of DEPTH software-visible control registers.
//   clk   in  : single clock, rising edge
//   rst   in  : asynchronous active-high reset (registers -> RESET_VAL,
//               rdata -> 0, ready -> 1)
//   addr  in  : register index
//   sel   in  : access request, accepted only while ready = 1
//   wr    in  : 1 = write, 0 = read
//   wdata in  : write data
//   rdata out : registered read data, held until the next accepted read
//   ready out : 1 = request accepted this cycle; low for one cycle after a read
// Writes take effect in one edge. Reads load rdata at the accept edge and
// drop ready for exactly one cycle. Indices >= DEPTH drop writes and read 0.
module reg_ctrl_unit
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           DEPTH      = DEF_DEPTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = DEF_RESET_VAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  sel,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  state_t                r_state;
  state_t                w_state_nxt;

  logic                  w_in_range;
  logic                  w_accept;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rd_val;

  assign w_in_range = ({1'b0, addr} < LP_DEPTH);
  assign w_accept   = sel && (r_state == IDLE);
  assign w_wr_acc   = w_accept && wr;
  assign w_rd_acc   = w_accept && !wr;
  assign w_rd_val   = w_in_range ? r_mem[addr] : '0;

  // Register array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '{default: RESET_VAL};
    end else if (w_wr_acc && w_in_range) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read data register, held between accepted reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= w_rd_val;
    end
  end

  // Handshake FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_rd_acc) w_state_nxt = BUSY;
      BUSY: w_state_nxt = IDLE;
    endcase
  end

  assign rdata = r_rdata;
  assign ready = (r_state == IDLE);

endmodule

// File: tb/tb_reg_ctrl_unit.sv
module tb_reg_ctrl_unit;
  import reg_ctrl_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 256;
  localparam logic [15:0] RV    = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  rif #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus (.clk(clk));

  reg_ctrl_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .RESET_VAL(RV)
  ) dut (
    .clk  (clk),
    .rst  (bus.rst),
    .addr (bus.addr),
    .sel  (bus.sel),
    .wr   (bus.wr),
    .wdata(bus.wdata),
    .rdata(bus.rdata),
    .ready(bus.ready)
  );

  // Behavioural model: register contents plus what the outputs must show.
  logic [15:0] model [256];
  logic [15:0] exp_rdata;
  logic        exp_ready;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [7:0] a);
    if (int'(a) < DEPTH) return model[a];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model[i] = RV;
    exp_rdata = 16'h0000;
    exp_ready = 1'b1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("ready", {31'b0, bus.ready}, {31'b0, exp_ready});
    check("rdata", {16'b0, bus.rdata}, {16'b0, exp_rdata});
  end

  task automatic idle(input int n);
    bus.sel = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    bus.addr = a; bus.wr = 1'b1; bus.wdata = d; bus.sel = 1'b1;
    @(posedge clk);
    if (int'(a) < DEPTH) model[a] = d;
    #1 bus.sel = 1'b0;
  endtask

  // Read; optionally present a write request (jaddr <- jdata) during BUSY,
  // which must be ignored.
  task automatic do_read(input logic [7:0] a, input bit junk,
                         input logic [7:0] jaddr, input logic [15:0] jdata,
                         output logic [15:0] got);
    bus.addr = a; bus.wr = 1'b0; bus.wdata = 16'($urandom); bus.sel = 1'b1;
    @(posedge clk);
    exp_rdata = model_rd(a);
    exp_ready = 1'b0;
    #1 got = bus.rdata;
    if (junk) begin
      bus.addr = jaddr; bus.wr = 1'b1; bus.wdata = jdata; bus.sel = 1'b1;
    end else begin
      bus.sel = 1'b0;
    end
    @(posedge clk);
    exp_ready = 1'b1;
    #1 bus.sel = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  a;
    bus.rst = 1'b1; bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 bus.rst = 1'b0;
    check("ready_after_reset", {31'b0, bus.ready}, 32'd1);
    check("rdata_after_reset", {16'b0, bus.rdata}, 32'd0);

    do_read(8'h00, 1'b0, 8'h00, 16'h0, v); check("rst_val_00", {16'b0, v}, 32'h1234);
    do_read(8'h7F, 1'b0, 8'h00, 16'h0, v); check("rst_val_7f", {16'b0, v}, 32'h1234);
    do_read(8'hFF, 1'b0, 8'h00, 16'h0, v); check("rst_val_ff", {16'b0, v}, 32'h1234);

    do_write(8'h10, 16'hBEEF);
    do_read(8'h10, 1'b0, 8'h00, 16'h0, v); check("wr_rd_10", {16'b0, v}, 32'hBEEF);

    do_read(8'h10, 1'b1, 8'h10, 16'h0000, v); check("busy_rd_10", {16'b0, v}, 32'hBEEF);
    do_read(8'h10, 1'b0, 8'h00, 16'h0, v); check("busy_ignored", {16'b0, v}, 32'hBEEF);

    do_write(8'h20, 16'h0001);
    do_write(8'h21, 16'h0002);
    do_write(8'h22, 16'h0003);
    do_read(8'h20, 1'b0, 8'h00, 16'h0, v); check("b2b_20", {16'b0, v}, 32'h0001);
    do_read(8'h21, 1'b0, 8'h00, 16'h0, v); check("b2b_21", {16'b0, v}, 32'h0002);
    do_read(8'h22, 1'b0, 8'h00, 16'h0, v); check("b2b_22", {16'b0, v}, 32'h0003);

    for (int n = 0; n < 50; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, 16'($urandom));
      end else begin
        do_read(a, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 15)), 16'($urandom), v);
        check("rand_rd", {16'b0, v}, {16'b0, model_rd(a)});
      end
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // Reset asserted while BUSY
    bus.addr = 8'h10; bus.wr = 1'b0; bus.sel = 1'b1;
    @(posedge clk);
    exp_rdata = model_rd(8'h10);
    exp_ready = 1'b0;
    #1 bus.sel = 1'b0;
    #2 bus.rst = 1'b1;
    model_reset();
    #1;
    check("midrd_rst_ready", {31'b0, bus.ready}, 32'd1);
    check("midrd_rst_rdata", {16'b0, bus.rdata}, 32'd0);
    @(posedge clk);
    #1 bus.rst = 1'b0;
    do_read(8'h10, 1'b0, 8'h00, 16'h0, v); check("midrd_rst_10", {16'b0, v}, 32'h1234);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
